// File: rtl/grad_frame_seq.sv
// Frame sequencer for the Sobel gradient stage: walks prime/run/flush/drain and tags valid window results.
// Pixels are accepted the same cycle as pix_valid & pix_ready; grad_out_valid trails its tag by GRAD_LAT cycles.
module grad_frame_seq #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int H_BLANK  = 2,
  parameter int GRAD_LAT = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        en_1,
  output logic        edg,
  output logic [3:0]  state,
  output logic [10:0] col,
  output logic [10:0] row,
  output logic        busy,
  output logic        grad_out_valid,
  output logic        frame_done
);

  typedef enum logic [3:0] {
    S_PRIME = 4'b0001,
    S_RUN   = 4'b0010,
    S_FLUSH = 4'b0100,
    S_IDLE  = 4'b1000
  } state_t;

  localparam logic [10:0] W_LAST    = 11'(IMG_W - 1);
  localparam logic [10:0] H_LAST    = 11'(IMG_H - 1);
  localparam logic [15:0] HB_LAST   = 16'(H_BLANK - 1);
  localparam logic [15:0] TAIL_LAST = 16'(H_BLANK + GRAD_LAT - 1);

  state_t              state_q, state_n;
  logic [10:0]         col_n, row_n;
  logic [15:0]         cnt_q, cnt_n;
  logic                pix_ready_n, edg_n, frame_done_n;
  logic                sh, tag;
  logic [GRAD_LAT-1:0] dl_q;

  assign en_1           = pix_valid & pix_ready;
  assign state          = state_q;
  assign busy           = ~state_q[3];
  assign grad_out_valid = dl_q[GRAD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      col        <= '0;
      row        <= '0;
      cnt_q      <= '0;
      pix_ready  <= 1'b0;
      edg        <= 1'b0;
      frame_done <= 1'b0;
      dl_q       <= '0;
    end else begin
      state_q    <= state_n;
      col        <= col_n;
      row        <= row_n;
      cnt_q      <= cnt_n;
      pix_ready  <= pix_ready_n;
      edg        <= edg_n;
      frame_done <= frame_done_n;
      dl_q[0]    <= tag;
      for (int i = 1; i < GRAD_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // Mirror of the gradient unit's own shift enable, so tags line up with its window.
  always_comb begin
    sh = 1'b0;
    case (state_q)
      S_PRIME, S_RUN: sh = en_1;
      S_FLUSH:        sh = ~edg;
      default:        sh = 1'b0;
    endcase
    tag = sh & (col >= 11'd2) & (row >= 11'd2);
  end

  always_comb begin
    state_n      = state_q;
    col_n        = col;
    row_n        = row;
    cnt_n        = cnt_q;
    pix_ready_n  = pix_ready;
    edg_n        = edg;
    frame_done_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n     = S_PRIME;
          pix_ready_n = 1'b1;
          col_n       = '0;
          row_n       = '0;
          edg_n       = 1'b0;
          cnt_n       = '0;
        end
      end
      S_PRIME, S_RUN: begin
        if (!edg) begin
          if (en_1) begin
            if (col == W_LAST) begin
              col_n       = '0;
              edg_n       = 1'b1;
              pix_ready_n = 1'b0;
              cnt_n       = '0;
            end else begin
              col_n = col + 11'd1;
            end
          end
        end else if (cnt_q == HB_LAST) begin
          edg_n = 1'b0;
          cnt_n = '0;
          row_n = row + 11'd1;
          if (row == H_LAST) begin
            state_n     = S_FLUSH;
            pix_ready_n = 1'b0;
          end else begin
            pix_ready_n = 1'b1;
            if (row == 11'd1) state_n = S_RUN;
          end
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      S_FLUSH: begin
        // One free-running line of shifts, then blank and latency drain as a single edg=1 tail.
        if (!edg) begin
          if (col == W_LAST) begin
            col_n = '0;
            edg_n = 1'b1;
            cnt_n = '0;
          end else begin
            col_n = col + 11'd1;
          end
        end else if (cnt_q == TAIL_LAST) begin
          state_n      = S_IDLE;
          edg_n        = 1'b0;
          row_n        = '0;
          cnt_n        = '0;
          frame_done_n = 1'b1;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_grad_frame_seq.sv
// Bench for grad_frame_seq with an 8x4 frame; grad_out_valid checked against a queue of expected cycles.
module tb_grad_frame_seq;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 2;
  localparam int GL = 6;

  logic        clk = 1'b0;
  logic        rst, start, pix_valid;
  logic        pix_ready, en_1, edg, busy, grad_out_valid, frame_done;
  logic [3:0]  state;
  logic [10:0] col, row;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int exp_q[$];

  grad_frame_seq #(.IMG_W(W), .IMG_H(H), .H_BLANK(HB), .GRAD_LAT(GL)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .en_1(en_1), .edg(edg), .state(state),
    .col(col), .row(row), .busy(busy), .grad_out_valid(grad_out_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every grad_out_valid must match the oldest expected cycle.
  always @(negedge clk) begin
    if (grad_out_valid) begin
      int e;
      ntests++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL gov_unexpected: valid at cycle %0d, none expected", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e) begin
          nfail++;
          $display("FAIL gov_cycle: valid at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
  end

  // Expected valid cycles for a frame whose start is driven in cycle t0.
  function automatic void push_expect(int t0, int stall_at, int stall_len);
    int k;
    for (int r = 0; r <= H; r++) begin
      for (int c = 0; c < W; c++) begin
        k = 1 + r * (W + HB) + c;
        if (stall_len > 0 && k >= stall_at) k += stall_len;
        if (r >= 2 && c >= 2) exp_q.push_back(t0 + k + GL);
      end
    end
  endfunction

  task automatic run_frame(input int stall_at, input int stall_len, input int extra_start,
                           output int run_c, output int flush_c, output int done_c,
                           output int en_n, output int gov_n, output int blank_n,
                           output int blank_bad, output int stall_bad, output int st_k1);
    bit done;
    run_c = -1; flush_c = -1; done_c = -1; en_n = 0; gov_n = 0;
    blank_n = 0; blank_bad = 0; stall_bad = 0; st_k1 = -1; done = 1'b0;
    push_expect(cyc, stall_at, stall_len);
    start = 1'b1;
    pix_valid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (k == 1) st_k1 = int'(state) | (pix_ready ? 16 : 0);
      if (state == 4'b0010 && run_c < 0) run_c = k;
      if (state == 4'b0100 && flush_c < 0) flush_c = k;
      if (en_1) en_n++;
      if (grad_out_valid) gov_n++;
      if ((state == 4'b0001 || state == 4'b0010) && edg) begin
        blank_n++;
        if (pix_ready || en_1) blank_bad++;
      end
      if (stall_len > 0 && k >= stall_at && k < stall_at + stall_len)
        if (en_1 || col != 11'd3 || row != 11'd2) stall_bad++;
      if (frame_done) begin
        done_c = k;
        done = 1'b1;
      end
      @(posedge clk); #1;
      start = (k + 1 == extra_start);
      pix_valid = !(stall_len > 0 && k + 1 >= stall_at && k + 1 < stall_at + stall_len);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; pix_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    ntests++; if (state !== 4'b1000) begin nfail++; $display("FAIL rst_state: got %b expected 1000", state); end
    ntests++; if ({pix_ready, edg, busy, grad_out_valid, frame_done, en_1} !== 6'b0) begin
      nfail++; $display("FAIL rst_flags: got %b expected 000000", {pix_ready, edg, busy, grad_out_valid, frame_done, en_1});
    end
    ntests++; if (col !== 11'd0 || row !== 11'd0) begin nfail++; $display("FAIL rst_colrow: got col=%0d row=%0d expected 0 0", col, row); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    ntests++; if (state !== 4'b1000) begin nfail++; $display("FAIL rst_start_ignored: got %b expected 1000", state); end
  endtask

  task automatic test_nominal;
    int run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1;
    @(posedge clk); #1;
    run_frame(0, 0, -1, run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1);
    ntests++; if (st_k1 !== 17) begin nfail++; $display("FAIL nom_prime_entry: got state|ready=%0d expected 17", st_k1); end
    ntests++; if (run_c !== 21) begin nfail++; $display("FAIL nom_run_cycle: got %0d expected 21", run_c); end
    ntests++; if (flush_c !== 41) begin nfail++; $display("FAIL nom_flush_cycle: got %0d expected 41", flush_c); end
    ntests++; if (done_c !== 57) begin nfail++; $display("FAIL nom_done_cycle: got %0d expected 57", done_c); end
    ntests++; if (en_n !== W * H) begin nfail++; $display("FAIL nom_en_count: got %0d expected %0d", en_n, W * H); end
    ntests++; if (gov_n !== 18) begin nfail++; $display("FAIL nom_gov_count: got %0d expected 18", gov_n); end
    ntests++; if (blank_n !== H * HB) begin nfail++; $display("FAIL blank_count: got %0d expected %0d", blank_n, H * HB); end
    ntests++; if (blank_bad !== 0) begin nfail++; $display("FAIL blank_ready: got %0d bad cycles expected 0", blank_bad); end
    ntests++; if (state !== 4'b1000 || busy !== 1'b0) begin nfail++; $display("FAIL nom_idle_after: got state=%b busy=%b expected 1000 0", state, busy); end
    ntests++; if (exp_q.size() !== 0) begin nfail++; $display("FAIL nom_sb_empty: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_stall;
    int run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1;
    repeat (3) @(posedge clk);
    #1;
    run_frame(24, 5, -1, run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1);
    ntests++; if (stall_bad !== 0) begin nfail++; $display("FAIL stall_frozen: got %0d bad cycles expected 0", stall_bad); end
    ntests++; if (done_c !== 62) begin nfail++; $display("FAIL stall_done_cycle: got %0d expected 62", done_c); end
    ntests++; if (en_n !== W * H) begin nfail++; $display("FAIL stall_en_count: got %0d expected %0d", en_n, W * H); end
    ntests++; if (gov_n !== 18) begin nfail++; $display("FAIL stall_gov_count: got %0d expected 18", gov_n); end
    ntests++; if (exp_q.size() !== 0) begin nfail++; $display("FAIL stall_sb_empty: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_midrun;
    int run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1;
    @(posedge clk); #1;
    push_expect(cyc, 0, 0);
    start = 1'b1; pix_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    @(negedge clk);
    ntests++; if (state !== 4'b0010 || row !== 11'd3) begin nfail++; $display("FAIL mid_pre: got state=%b row=%0d expected 0010 3", state, row); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    ntests++; if (state !== 4'b1000 || busy !== 1'b0) begin nfail++; $display("FAIL mid_idle: got state=%b busy=%b expected 1000 0", state, busy); end
    ntests++; if ({pix_ready, edg, col, row} !== 24'd0) begin nfail++; $display("FAIL mid_outputs: got ready=%b edg=%b col=%0d row=%0d expected 0", pix_ready, edg, col, row); end
    repeat (12) @(posedge clk);
    #1;
    run_frame(0, 0, -1, run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1);
    ntests++; if (done_c !== 57) begin nfail++; $display("FAIL mid_rerun_done: got %0d expected 57", done_c); end
    ntests++; if (gov_n !== 18) begin nfail++; $display("FAIL mid_rerun_gov: got %0d expected 18", gov_n); end
  endtask

  task automatic test_start_busy;
    int run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(0, 0, 10, run_c, flush_c, done_c, en_n, gov_n, blank_n, blank_bad, stall_bad, st_k1);
    ntests++; if (run_c !== 21 || flush_c !== 41) begin nfail++; $display("FAIL busy_phase: got run=%0d flush=%0d expected 21 41", run_c, flush_c); end
    ntests++; if (done_c !== 57) begin nfail++; $display("FAIL busy_done: got %0d expected 57", done_c); end
    ntests++; if (en_n !== W * H || gov_n !== 18) begin nfail++; $display("FAIL busy_counts: got en=%0d gov=%0d expected 32 18", en_n, gov_n); end
    ntests++; if (exp_q.size() !== 0) begin nfail++; $display("FAIL busy_sb_empty: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
    test_reset;
    test_nominal;
    test_stall;
    test_reset_midrun;
    test_start_busy;
    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
